// File: rtl/sr_pkg.sv
// rtl/sr_pkg.sv - shared types and constants for the serial deserializer slice
package sr_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    localparam int SR_WIDTH = 8;

    // FIFO pointer width: index bits plus one wrap bit
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sr_deser_fifo_if.sv
// rtl/sr_deser_fifo_if.sv - word output stream between deserializer FIFO and consumer
interface sr_deser_fifo_if
    import sr_pkg::*;
#(
    parameter int WIDTH = SR_WIDTH
);
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);

endinterface

// File: rtl/sr_deser_fifo_sync_fifo.sv
// rtl/sr_deser_fifo_sync_fifo.sv - registered circular-buffer FIFO with wrap-bit pointers
module sync_fifo
    import sr_pkg::*;
#(
    parameter  int WIDTH = SR_WIDTH,
    parameter  int DEPTH = 4,
    localparam int PW    = ptr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic [PW-1:0]    level
);
    localparam int AW = PW - 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointer compare: equal index with differing wrap bit means full
    always_comb begin
        empty   = (wr_ptr == rd_ptr);
        full    = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        rdata   = mem[rd_ptr[AW-1:0]];
        level   = wr_ptr - rd_ptr;
    end

    // Storage and pointer update; contents cleared so the head reads zero after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= wdata;
                wr_ptr              <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

endmodule

// File: rtl/sr_deser_fifo.sv
// rtl/sr_deser_fifo.sv - MSB-first serial-to-word deserializer with frame alignment and output FIFO
module sr_deser_fifo
    import sr_pkg::*;
#(
    parameter  int WIDTH = SR_WIDTH,
    parameter  int DEPTH = 4,
    localparam int LW    = ptr_w(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ser_in,
    input  logic                 bit_en,
    input  logic                 frame_start,
    input  logic                 err_clr,
    sr_deser_fifo_if.master      out_if,
    output logic                 frame_err,
    output logic                 overflow,
    output logic [LW-1:0]        level
);
    localparam int CW = $clog2(WIDTH + 1);

    state_e           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] asm_q;
    logic             push_q;
    logic [WIDTH-1:0] push_data_q;
    logic             frame_err_q;
    logic             overflow_q;

    logic [WIDTH-1:0] next_word;
    logic             last_bit;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;
    logic             drop;

    // Next assembly value and drop detection
    always_comb begin
        next_word = (asm_q << 1) | WIDTH'(ser_in);
        last_bit  = (cnt == CW'(WIDTH - 1));
        fifo_pop  = out_if.out_ready && !fifo_empty;
        drop      = push_q && fifo_full && !fifo_pop;
    end

    // Framing FSM: aligns on frame_start, assembles bits, hands finished words to the FIFO one cycle later
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            asm_q       <= '0;
            push_q      <= 1'b0;
            push_data_q <= '0;
            frame_err_q <= 1'b0;
        end else begin
            push_q      <= 1'b0;
            frame_err_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bit_en && frame_start) begin
                        if (WIDTH == 1) begin
                            push_q      <= 1'b1;
                            push_data_q <= WIDTH'(ser_in);
                        end else begin
                            asm_q <= WIDTH'(ser_in);
                            cnt   <= CW'(1);
                            state <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (bit_en) begin
                        if (frame_start) begin
                            asm_q       <= WIDTH'(ser_in);
                            cnt         <= CW'(1);
                            frame_err_q <= 1'b1;
                        end else if (last_bit) begin
                            push_q      <= 1'b1;
                            push_data_q <= next_word;
                            asm_q       <= '0;
                            cnt         <= '0;
                            state       <= ST_IDLE;
                        end else begin
                            asm_q <= next_word;
                            cnt   <= cnt + CW'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Sticky overflow; a fresh drop outranks a clear in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else if (drop) begin
            overflow_q <= 1'b1;
        end else if (err_clr) begin
            overflow_q <= 1'b0;
        end
    end

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_q),
        .wdata (push_data_q),
        .full  (fifo_full),
        .pop   (out_if.out_ready),
        .rdata (out_if.out_data),
        .empty (fifo_empty),
        .level (level)
    );

    assign out_if.out_valid = !fifo_empty;
    assign frame_err        = frame_err_q;
    assign overflow         = overflow_q;

endmodule

// File: tb/tb_sr_deser_fifo.sv
// tb/tb_sr_deser_fifo.sv - self-checking bench for sr_deser_fifo
module tb_sr_deser_fifo;
    import sr_pkg::*;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int LW    = ptr_w(DEPTH);

    logic          clk = 1'b0;
    logic          rst;
    logic          ser_in;
    logic          bit_en;
    logic          frame_start;
    logic          err_clr;
    logic          frame_err;
    logic          overflow;
    logic [LW-1:0] level;

    sr_deser_fifo_if #(.WIDTH(WIDTH)) bus ();

    sr_deser_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .ser_in      (ser_in),
        .bit_en      (bit_en),
        .frame_start (frame_start),
        .err_clr     (err_clr),
        .out_if      (bus.master),
        .frame_err   (frame_err),
        .overflow    (overflow),
        .level       (level)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int fe_count = 0;
    logic [WIDTH-1:0] sb [$];

    typedef struct {
        logic [WIDTH-1:0] word;
        int               gap_pos;
        int               gap_len;
        logic [WIDTH-1:0] expect_word;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every accepted head word must match the oldest expected word
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got %0h expected none", bus.out_data);
            end else begin
                check("sb_word", 32'(bus.out_data), 32'(sb.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (frame_err) fe_count++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [WIDTH-1:0] w, input int nbits, input int gap_pos,
                             input int gap_len, input bit with_start);
        for (int i = 0; i < nbits; i++) begin
            if (i == gap_pos) begin
                bit_en      = 1'b0;
                frame_start = 1'b0;
                for (int g = 0; g < gap_len; g++) tick();
            end
            ser_in      = w[WIDTH-1-i];
            bit_en      = 1'b1;
            frame_start = with_start && (i == 0);
            tick();
        end
        bit_en      = 1'b0;
        frame_start = 1'b0;
        ser_in      = 1'b0;
    endtask

    task automatic drain(input int budget);
        bit done = 1'b0;
        tick();
        bus.out_ready = 1'b1;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            if (!bus.out_valid) done = 1'b1;
        end
        check("drain_done", 32'(done), 32'd1);
        tick();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        int fe0;
        rst           = 1'b1;
        ser_in        = 1'b0;
        bit_en        = 1'b0;
        frame_start   = 1'b0;
        err_clr       = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_data", 32'(bus.out_data), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);

        // First word, consumer stalled: latency and head contents
        tick();
        send_bits(8'hA5, 8, -1, 0, 1'b1);
        sb.push_back(8'hA5);
        @(negedge clk);
        check("lat_valid_early", 32'(bus.out_valid), 32'd0);
        tick();
        @(negedge clk);
        check("lat_valid", 32'(bus.out_valid), 32'd1);
        check("lat_data", 32'(bus.out_data), 32'hA5);
        check("lat_level", 32'(level), 32'd1);
        check("lat_frame_err", 32'(frame_err), 32'd0);
        drain(20);

        // Table: streaming words with bit_en gaps, consumer always ready
        vecs[0] = '{8'h3C, 4, 3, 8'h3C};
        vecs[1] = '{8'h00, -1, 0, 8'h00};
        vecs[2] = '{8'hFF, 0, 2, 8'hFF};
        vecs[3] = '{8'h5A, 7, 1, 8'h5A};
        vecs[4] = '{8'hC3, 2, 5, 8'hC3};
        fe0 = fe_count;
        tick();
        bus.out_ready = 1'b1;
        for (int v = 0; v < 5; v++) begin
            sb.push_back(vecs[v].expect_word);
            send_bits(vecs[v].word, 8, vecs[v].gap_pos, vecs[v].gap_len, 1'b1);
        end
        drain(20);
        check("tbl_no_frame_err", 32'(fe_count - fe0), 32'd0);
        check("tbl_sb_empty", 32'(sb.size()), 32'd0);

        // Early frame_start aborts the partial word
        fe0 = fe_count;
        bus.out_ready = 1'b1;
        send_bits(8'hFF, 5, -1, 0, 1'b1);
        sb.push_back(8'h81);
        send_bits(8'h81, 8, -1, 0, 1'b1);
        drain(20);
        check("abort_fe_pulses", 32'(fe_count - fe0), 32'd1);
        check("abort_sb_empty", 32'(sb.size()), 32'd0);

        // Overflow: five words into a four-deep FIFO
        bus.out_ready = 1'b0;
        for (int w = 1; w <= 5; w++) begin
            if (w <= DEPTH) sb.push_back(WIDTH'(w));
            send_bits(WIDTH'(w), 8, -1, 0, 1'b1);
            if (w == DEPTH) begin
                tick();
                @(negedge clk);
                check("ovf_before", 32'(overflow), 32'd0);
            end
        end
        tick();
        @(negedge clk);
        check("ovf_level", 32'(level), 32'd4);
        check("ovf_set", 32'(overflow), 32'd1);
        drain(20);
        check("ovf_drained_valid", 32'(bus.out_valid), 32'd0);
        check("ovf_sb_empty", 32'(sb.size()), 32'd0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        @(negedge clk);
        check("ovf_cleared", 32'(overflow), 32'd0);

        // Full FIFO: push of 0x77 coincides with a single pop
        tick();
        sb.push_back(8'h11);
        sb.push_back(8'h22);
        sb.push_back(8'h33);
        sb.push_back(8'h44);
        sb.push_back(8'h77);
        send_bits(8'h11, 8, -1, 0, 1'b1);
        send_bits(8'h22, 8, -1, 0, 1'b1);
        send_bits(8'h33, 8, -1, 0, 1'b1);
        send_bits(8'h44, 8, -1, 0, 1'b1);
        tick();
        @(negedge clk);
        check("pp_full_level", 32'(level), 32'd4);
        tick();
        send_bits(8'h77, 8, -1, 0, 1'b1);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        @(negedge clk);
        check("pp_level", 32'(level), 32'd4);
        check("pp_overflow", 32'(overflow), 32'd0);
        drain(20);
        check("pp_sb_empty", 32'(sb.size()), 32'd0);

        // Reset mid-frame with two words queued
        send_bits(8'h12, 8, -1, 0, 1'b1);
        send_bits(8'h34, 8, -1, 0, 1'b1);
        tick();
        send_bits(8'hE7, 4, -1, 0, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("mrst_valid", 32'(bus.out_valid), 32'd0);
        check("mrst_level", 32'(level), 32'd0);
        tick();
        sb.push_back(8'h5A);
        send_bits(8'h5A, 8, -1, 0, 1'b1);
        tick();
        @(negedge clk);
        check("mrst_level_after", 32'(level), 32'd1);
        drain(20);
        check("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sr_deser_fifo.md
Name: sr_deser_fifo

Overview:
- Downstream neighbour of the byte-wide parallel-load shift-left register.
- Samples that register's serial MSB output bit by bit and reassembles MSB-first words.
- Uses a frame-start strobe for alignment and buffers completed words in a small FIFO with a valid/ready consumer interface.
- Reports misaligned frames and dropped words.

Parameters:
- WIDTH, 8, bits per word; also the output data width.
- DEPTH, 4, FIFO entries; must be a power of two, at least 2.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- ser_in  in  1  serial data bit, MSB first (upstream reg_shift[WIDTH-1])
- bit_en  in  1  qualifies ser_in; a bit is captured only when high
- frame_start  in  1  marks the current bit_en bit as a word MSB
- out_data  out  WIDTH  FIFO head word
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts head when out_valid && out_ready
- frame_err  out  1  one-cycle pulse: word aborted by an early frame_start
- overflow  out  1  sticky: a completed word was dropped because the FIFO was full
- err_clr  in  1  clears overflow
- level  out  clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH

Behaviour:
- Reset (rst high at a clk edge):
  - state=IDLE, bit count=0, assembly register=0, FIFO empty.
  - Outputs: out_valid=0, out_data=0, level=0, frame_err=0, overflow=0.
  - Applies mid-frame too: partial word and FIFO contents are discarded.
- FSM states: IDLE, SHIFT.
- IDLE:
  - bit_en && frame_start: asm = {0.., ser_in}, cnt=1, go to SHIFT.
  - bit_en without frame_start is ignored.
- SHIFT:
  - Each bit_en && !frame_start: asm = {asm[WIDTH-2:0], ser_in}, cnt++.
  - The capture that makes cnt reach WIDTH produces a complete word {asm[WIDTH-2:0], ser_in}: push it, go to IDLE, cnt=0.
  - bit_en && frame_start while in SHIFT:
    - The partial word is discarded and frame_err pulses high the next cycle.
    - The current bit restarts assembly as the new MSB (cnt=1, stay in SHIFT).
  - Gaps in bit_en are allowed; the state holds.
  - frame_start without bit_en is ignored.
- WIDTH=1 degenerate case: every bit_en && frame_start pushes immediately; state stays IDLE.
- Latency: the final bit is captured at edge N; the word is visible at out_data with out_valid=1 after edge N+1 (registered FIFO, no bypass).
- FIFO:
  - Circular buffer; read/write pointers are clog2(DEPTH)+1 bits with a wrap bit.
  - full = pointers equal except MSB; empty = pointers equal.
  - out_data is driven combinationally from mem[rd_ptr] and holds stable while out_valid && !out_ready.
  - Pop occurs when out_valid && out_ready. out_ready while empty has no effect.
  - Push and pop in the same cycle while full: both happen, level unchanged, no overflow.
  - Push and pop in the same cycle while empty: push only (no data to pop); level becomes 1.
  - Push while full with no pop: word dropped, overflow set at next edge. FIFO contents are unchanged.
- overflow:
  - Cleared by err_clr at a clock edge.
  - If err_clr and a new drop coincide, overflow stays set (set wins).
- level updates in the same edge as push/pop; it never exceeds DEPTH and never wraps.

Decomposition:
- Shared package sr_pkg:
  - FSM state enum (ST_IDLE, ST_SHIFT).
  - Default word width constant SR_WIDTH=8, shared with the upstream shift register.
  - Pointer-width helper function.
- One natural sub-module: sync_fifo (parameters WIDTH, DEPTH; ports push/wdata/full, pop/rdata/empty, level).
  - sr_deser_fifo instantiates it and contains only the FSM, counter, assembly register and error logic.

Test Plan:
- Reset then frame_start+bit_en on first bit of 0xA5 MSB-first, 8 consecutive bit_en cycles, out_ready=0 -> out_valid rises one cycle after bit 8; out_data=0xA5; level=1; frame_err=0.
- Send 0x3C with bit_en low for 3 cycles between bits 4 and 5 -> out_data=0x3C; no extra or missing words.
- Send 5 bits of 0xFF, then assert frame_start with the first bit of 0x81, then 7 more bits -> frame_err pulses exactly once; only 0x81 is enqueued.
- out_ready=0; send 5 words 0x01..0x05 with DEPTH=4 -> level=4; overflow=1 after the 5th word. Drain with out_ready=1 -> 0x01,0x02,0x03,0x04 in order, then out_valid=0. Pulse err_clr -> overflow=0.
- FIFO full, out_ready=1 held while the final bit of 0x77 arrives -> pop and push in the same cycle; level stays 4; overflow=0; 0x77 emerges last.
- Assert rst after bit 4 of a word with 2 words queued -> next cycle out_valid=0, level=0; next complete word 0x5A is received correctly.
